// File: rtl/dim_stream_gen_pkg.sv
// Shared definitions for the dimming input-unit stream generator:
// FSM state encoding and the common field widths.
package dim_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    LINE_WAIT  = 2'd1,
    ACTIVE     = 2'd2,
    FRAME_DONE = 2'd3
  } dimState_t;

  localparam int PIX_GROUP_W  = 192;
  localparam int BLOCK_ADDR_W = 4;
  localparam int LINE_CNT_W   = 7;

endpackage

// File: rtl/dim_stream_gen_if.sv
// Video-in / dimming-out bundle of the stream generator.
// master: the generator itself; slave: the input-unit buffer side.
interface dim_stream_gen_if
  import dim_pkg::*;
#(
  parameter int H_BLOCKS = 24
);
  logic                    iVS;
  logic                    iDE;
  logic [PIX_GROUP_W-1:0]  iPixelData;
  logic [H_BLOCKS-1:0]     oH_Duty;
  logic [PIX_GROUP_W-1:0]  oPixelData;
  logic [BLOCK_ADDR_W-1:0] oV_Address;
  logic                    oV_Duty;
  logic                    oOU_en;
  logic                    oALG_rst;
  logic [LINE_CNT_W-1:0]   oV_Block_Duty_Count;
  logic                    oLineErr;

  modport master (
    input  iVS, iDE, iPixelData,
    output oH_Duty, oPixelData, oV_Address, oV_Duty, oOU_en, oALG_rst,
           oV_Block_Duty_Count, oLineErr
  );

  modport slave (
    output iVS, iDE, iPixelData,
    input  oH_Duty, oPixelData, oV_Address, oV_Duty, oOU_en, oALG_rst,
           oV_Block_Duty_Count, oLineErr
  );
endinterface

// File: rtl/dim_stream_gen_zone_counter.sv
// Horizontal zone tracker: counts 8-pixel groups inside a line, steps the
// zone every GROUPS_PER_HBLOCK groups, and offers the one-hot zone of the
// group currently presented plus the saturating group total of the line.
module dim_zone_counter #(
  parameter int H_BLOCKS          = 24,
  parameter int GROUPS_PER_HBLOCK = 10,
  parameter int TOT_W             = 8
) (
  input  logic                iODCK,
  input  logic                iRST,
  input  logic                iClear,
  input  logic                iAdvance,
  output logic [H_BLOCKS-1:0] oOneHot,
  output logic                oInRange,
  output logic [TOT_W-1:0]    oGroupTotal
);
  localparam int ZONE_W = $clog2(H_BLOCKS + 1);
  localparam logic [7:0]        GRP_LAST = 8'(GROUPS_PER_HBLOCK - 1);
  localparam logic [ZONE_W-1:0] ZONE_END = ZONE_W'(H_BLOCKS);
  // Saturating one past a full line keeps overlong lines distinguishable.
  localparam logic [TOT_W-1:0]  TOT_MAX  = TOT_W'(H_BLOCKS * GROUPS_PER_HBLOCK + 1);

  logic [7:0]        grpCnt;
  logic [ZONE_W-1:0] zoneCnt;
  logic [TOT_W-1:0]  total;

  // Zone decode for the group being accepted this cycle.
  always_comb begin
    oInRange = (zoneCnt < ZONE_END);
    oOneHot  = '0;
    if (oInRange) oOneHot = H_BLOCKS'(1) << zoneCnt;
  end

  assign oGroupTotal = total;

  // Group/zone/total counters, cleared at line end and frame start.
  always_ff @(posedge iODCK or posedge iRST) begin
    if (iRST) begin
      grpCnt  <= '0;
      zoneCnt <= '0;
      total   <= '0;
    end else if (iClear) begin
      grpCnt  <= '0;
      zoneCnt <= '0;
      total   <= '0;
    end else if (iAdvance) begin
      if (total != TOT_MAX) total <= total + 1'b1;
      if (oInRange) begin
        if (grpCnt == GRP_LAST) begin
          grpCnt  <= '0;
          zoneCnt <= zoneCnt + 1'b1;
        end else begin
          grpCnt <= grpCnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/dim_stream_gen.sv
// Transmit-side generator for the dimming input-unit interface.
// Turns DE/VS video into registered zone duty, vertical block address/line
// index, output-unit enable and algorithm reset.
// Optional feature: define DIM_STREAM_GEN_LINE_CHECK_EN to enable the sticky
// line-length error flag oLineErr (tied 0 otherwise).
module dim_stream_gen
  import dim_pkg::*;
#(
  parameter int H_BLOCKS          = 24,
  parameter int GROUPS_PER_HBLOCK = 10,
  parameter int V_BLOCKS          = 16,
  parameter int LINES_PER_VBLOCK  = 68
) (
  input logic              iODCK,
  input logic              iRST,
  dim_stream_gen_if.master bus
);
  localparam int GROUPS_PER_LINE = H_BLOCKS * GROUPS_PER_HBLOCK;
  localparam int TOT_W = $clog2(GROUPS_PER_LINE + 2);
  localparam logic [LINE_CNT_W-1:0]   LINE_LAST  = LINE_CNT_W'(LINES_PER_VBLOCK - 1);
  localparam logic [BLOCK_ADDR_W-1:0] BLOCK_LAST = BLOCK_ADDR_W'(V_BLOCKS - 1);

  dimState_t               state;
  logic                    vsPrev;
  logic [LINE_CNT_W-1:0]   lineCnt;
  logic [BLOCK_ADDR_W-1:0] blockCnt;
  logic                    vsRise;
  logic                    groupValid;
  logic                    lineEnd;
  logic                    zoneClear;
  logic [H_BLOCKS-1:0]     zoneOneHot;
  logic                    zoneInRange;
  logic [TOT_W-1:0]        groupTotal;

  // Frame-start and line event decode; VS wins over DE in the same cycle.
  always_comb begin
    vsRise     = bus.iVS & ~vsPrev;
    groupValid = ((state == LINE_WAIT) || (state == ACTIVE)) && bus.iDE && !vsRise;
    lineEnd    = (state == ACTIVE) && !bus.iDE && !vsRise;
    zoneClear  = vsRise || lineEnd;
  end

  dim_zone_counter #(
    .H_BLOCKS         (H_BLOCKS),
    .GROUPS_PER_HBLOCK(GROUPS_PER_HBLOCK),
    .TOT_W            (TOT_W)
  ) uZone (
    .iODCK      (iODCK),
    .iRST       (iRST),
    .iClear     (zoneClear),
    .iAdvance   (groupValid),
    .oOneHot    (zoneOneHot),
    .oInRange   (zoneInRange),
    .oGroupTotal(groupTotal)
  );

  // Frame FSM with line/block counters and the registered output bundle.
  // Address/line outputs are copies of the counters one cycle late, so the
  // oOU_en cycle still shows the completed block and its last line.
  always_ff @(posedge iODCK or posedge iRST) begin
    if (iRST) begin
      state                   <= WAIT_FRAME;
      vsPrev                  <= 1'b1;  // VS already high out of reset is not a rise
      lineCnt                 <= '0;
      blockCnt                <= '0;
      bus.oH_Duty             <= '0;
      bus.oPixelData          <= '0;
      bus.oV_Address          <= '0;
      bus.oV_Duty             <= 1'b0;
      bus.oOU_en              <= 1'b0;
      bus.oALG_rst            <= 1'b0;
      bus.oV_Block_Duty_Count <= '0;
    end else begin
      vsPrev                  <= bus.iVS;
      bus.oPixelData          <= bus.iPixelData;
      bus.oV_Duty             <= groupValid && zoneInRange;
      bus.oH_Duty             <= groupValid ? zoneOneHot : '0;
      bus.oV_Address          <= blockCnt;
      bus.oV_Block_Duty_Count <= lineCnt;
      bus.oALG_rst            <= vsRise;
      bus.oOU_en              <= 1'b0;
      if (vsRise) begin
        lineCnt  <= '0;
        blockCnt <= '0;
        state    <= LINE_WAIT;
      end else begin
        case (state)
          LINE_WAIT: if (bus.iDE) state <= ACTIVE;
          ACTIVE: begin
            if (!bus.iDE) begin
              if (lineCnt != LINE_LAST) begin
                lineCnt <= lineCnt + 1'b1;
                state   <= LINE_WAIT;
              end else begin
                bus.oOU_en <= 1'b1;
                lineCnt    <= '0;
                if (blockCnt != BLOCK_LAST) begin
                  blockCnt <= blockCnt + 1'b1;
                  state    <= LINE_WAIT;
                end else begin
                  state <= FRAME_DONE;
                end
              end
            end
          end
          WAIT_FRAME, FRAME_DONE: state <= state;
          default: state <= WAIT_FRAME;
        endcase
      end
    end
  end

`ifdef DIM_STREAM_GEN_LINE_CHECK_EN
  // Sticky line-length error, cleared only by reset or a new frame.
  always_ff @(posedge iODCK or posedge iRST) begin
    if (iRST) begin
      bus.oLineErr <= 1'b0;
    end else if (vsRise) begin
      bus.oLineErr <= 1'b0;
    end else if (lineEnd && (groupTotal != TOT_W'(GROUPS_PER_LINE))) begin
      bus.oLineErr <= 1'b1;
    end
  end
`else
  logic unusedGroupTotal;
  assign unusedGroupTotal = ^groupTotal;
  assign bus.oLineErr     = 1'b0;
`endif
endmodule

// File: tb/tb_dim_stream_gen.sv
// Scoreboard bench for dim_stream_gen with a 4-zone x 2-group line,
// 3 lines per block and 2 blocks per frame.
module tb_dim_stream_gen;
  import dim_pkg::*;

`ifdef DIM_STREAM_GEN_LINE_CHECK_EN
  localparam logic LC = 1'b1;
`else
  localparam logic LC = 1'b0;
`endif
  // Observed vector layout: {hDuty[3:0], vDuty, algRst, ouEn, vAddr[3:0], cnt[6:0], lineErr}
  localparam logic [18:0] M_ALL   = 19'h7FFFF;
  localparam logic [18:0] M_NOPOS = 19'h7F001;

  typedef struct packed {
    logic         vs;
    logic         de;
    logic [191:0] pix;
  } stim_t;

  typedef struct packed {
    logic [18:0]  val;
    logic [18:0]  mask;
    logic [191:0] pix;
  } exp_t;

  logic clk;
  logic rst;
  int   testsRun;
  int   failCnt;
  stim_t stimQ[$];
  exp_t  expQ[$];

  dim_stream_gen_if #(.H_BLOCKS(4)) bus ();

  dim_stream_gen #(
    .H_BLOCKS         (4),
    .GROUPS_PER_HBLOCK(2),
    .V_BLOCKS         (2),
    .LINES_PER_VBLOCK (3)
  ) dut (
    .iODCK(clk),
    .iRST (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] mk(input logic [3:0] h, input logic vd, input logic alg,
                                     input logic ou, input int addr, input int cnt,
                                     input logic err);
    return {h, vd, alg, ou, 4'(addr), 7'(cnt), err};
  endfunction

  function automatic logic [18:0] obsVec();
    return {bus.oH_Duty, bus.oV_Duty, bus.oALG_rst, bus.oOU_en, bus.oV_Address,
            bus.oV_Block_Duty_Count, bus.oLineErr};
  endfunction

  // Queue one stimulus cycle and the output expected one cycle later.
  task automatic add(input logic vs, input logic de, input logic [18:0] val,
                     input logic [18:0] mask);
    stim_t s;
    exp_t  e;
    logic [191:0] p;
    p = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    s.vs = vs; s.de = de; s.pix = p;
    e.val = val; e.mask = mask; e.pix = p;
    stimQ.push_back(s);
    expQ.push_back(e);
  endtask

  // VS rising pulse followed by one settle cycle.
  task automatic addVs();
    add(1'b1, 1'b0, mk(4'h0, 0, 1, 0, 0, 0, 0), M_NOPOS);
    add(1'b0, 1'b0, mk(4'h0, 0, 0, 0, 0, 0, 0), M_ALL);
  endtask

  // A line of n DE groups then idle cycles; groups 0..7 map to zone i/2.
  task automatic addLine(input int n, input logic live, input int addr, input int cnt,
                         input logic ou, input int nAddr, input int nCnt,
                         input logic eB, input logic eA, input int idle);
    for (int i = 0; i < n; i++) begin
      logic [3:0] h;
      logic       vd;
      vd = live && (i < 8);
      h  = vd ? (4'b0001 << (i / 2)) : 4'h0;
      add(1'b0, 1'b1, mk(h, vd, 0, 0, addr, cnt, eB), M_ALL);
    end
    for (int i = 0; i < idle; i++) begin
      if (i == 0) add(1'b0, 1'b0, mk(4'h0, 0, 0, ou, addr, cnt, eA), M_ALL);
      else        add(1'b0, 1'b0, mk(4'h0, 0, 0, 0, nAddr, nCnt, eA), M_ALL);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.iVS = 1'b1;
    bus.iDE = 1'b1;
    bus.iPixelData = {6{32'hA5A5_5A5A}};
    repeat (3) @(negedge clk);
    testsRun++;
    if (obsVec() !== 19'h0) begin
      failCnt++;
      $display("FAIL reset_ctrl: got %h want 0", obsVec());
    end
    testsRun++;
    if (bus.oPixelData !== 192'h0) begin
      failCnt++;
      $display("FAIL reset_pix: got %h want 0", bus.oPixelData);
    end
    rst = 1'b0;
    // VS high out of reset is not a frame start; DE before a frame is ignored.
    add(1'b1, 1'b1, mk(4'h0, 0, 0, 0, 0, 0, 0), M_ALL);
    add(1'b1, 1'b1, mk(4'h0, 0, 0, 0, 0, 0, 0), M_ALL);
    add(1'b0, 1'b0, mk(4'h0, 0, 0, 0, 0, 0, 0), M_ALL);
    for (int c = 0; stimQ.size() > 0; c++) begin
      stim_t s; exp_t e; logic [18:0] o;
      s = stimQ.pop_front();
      bus.iVS = s.vs; bus.iDE = s.de; bus.iPixelData = s.pix;
      @(posedge clk); @(negedge clk);
      e = expQ.pop_front(); o = obsVec(); testsRun++;
      if (((o & e.mask) !== (e.val & e.mask)) || (bus.oPixelData !== e.pix)) begin
        failCnt++;
        $display("FAIL reset_release cyc%0d: got %h pix %h want %h mask %h pix %h",
                 c, o, bus.oPixelData, e.val, e.mask, e.pix);
      end
    end
  endtask

  task automatic test_first_line();
    addVs();
    addLine(8, 1, 0, 0, 0, 0, 1, 0, 0, 2);
    for (int c = 0; stimQ.size() > 0; c++) begin
      stim_t s; exp_t e; logic [18:0] o;
      s = stimQ.pop_front();
      bus.iVS = s.vs; bus.iDE = s.de; bus.iPixelData = s.pix;
      @(posedge clk); @(negedge clk);
      e = expQ.pop_front(); o = obsVec(); testsRun++;
      if (((o & e.mask) !== (e.val & e.mask)) || (bus.oPixelData !== e.pix)) begin
        failCnt++;
        $display("FAIL first_line cyc%0d: got %h pix %h want %h mask %h pix %h",
                 c, o, bus.oPixelData, e.val, e.mask, e.pix);
      end
    end
  endtask

  task automatic test_block_pulses();
    addVs();
    for (int k = 0; k < 6; k++) begin
      addLine(8, 1, k / 3, k % 3, (k % 3) == 2, ((k + 1) / 3 > 1) ? 1 : (k + 1) / 3,
              (k + 1) % 3, 0, 0, 2);
    end
    // Seventh line arrives after the frame is done: no duty, no pulse.
    addLine(8, 0, 1, 0, 0, 1, 0, 0, 0, 2);
    for (int c = 0; stimQ.size() > 0; c++) begin
      stim_t s; exp_t e; logic [18:0] o;
      s = stimQ.pop_front();
      bus.iVS = s.vs; bus.iDE = s.de; bus.iPixelData = s.pix;
      @(posedge clk); @(negedge clk);
      e = expQ.pop_front(); o = obsVec(); testsRun++;
      if (((o & e.mask) !== (e.val & e.mask)) || (bus.oPixelData !== e.pix)) begin
        failCnt++;
        $display("FAIL block_pulses cyc%0d: got %h pix %h want %h mask %h pix %h",
                 c, o, bus.oPixelData, e.val, e.mask, e.pix);
      end
    end
  endtask

  task automatic test_mid_line_vs();
    addVs();
    for (int k = 0; k < 4; k++) begin
      addLine(8, 1, k / 3, k % 3, (k % 3) == 2, (k + 1) / 3, (k + 1) % 3, 0, 0, 2);
    end
    addLine(4, 1, 1, 1, 0, 1, 1, 0, 0, 0);
    add(1'b1, 1'b1, mk(4'h0, 0, 1, 0, 0, 0, 0), M_NOPOS);
    add(1'b0, 1'b0, mk(4'h0, 0, 0, 0, 0, 0, 0), M_ALL);
    addLine(8, 1, 0, 0, 0, 0, 1, 0, 0, 2);
    for (int c = 0; stimQ.size() > 0; c++) begin
      stim_t s; exp_t e; logic [18:0] o;
      s = stimQ.pop_front();
      bus.iVS = s.vs; bus.iDE = s.de; bus.iPixelData = s.pix;
      @(posedge clk); @(negedge clk);
      e = expQ.pop_front(); o = obsVec(); testsRun++;
      if (((o & e.mask) !== (e.val & e.mask)) || (bus.oPixelData !== e.pix)) begin
        failCnt++;
        $display("FAIL mid_line_vs cyc%0d: got %h pix %h want %h mask %h pix %h",
                 c, o, bus.oPixelData, e.val, e.mask, e.pix);
      end
    end
  endtask

  task automatic test_long_line();
    addVs();
    addLine(10, 1, 0, 0, 0, 0, 1, 0, LC, 2);
    addLine(8, 1, 0, 1, 0, 0, 2, LC, LC, 2);
    addVs();
    addLine(8, 1, 0, 0, 0, 0, 1, 0, 0, 2);
    for (int c = 0; stimQ.size() > 0; c++) begin
      stim_t s; exp_t e; logic [18:0] o;
      s = stimQ.pop_front();
      bus.iVS = s.vs; bus.iDE = s.de; bus.iPixelData = s.pix;
      @(posedge clk); @(negedge clk);
      e = expQ.pop_front(); o = obsVec(); testsRun++;
      if (((o & e.mask) !== (e.val & e.mask)) || (bus.oPixelData !== e.pix)) begin
        failCnt++;
        $display("FAIL long_line cyc%0d: got %h pix %h want %h mask %h pix %h",
                 c, o, bus.oPixelData, e.val, e.mask, e.pix);
      end
    end
  endtask

  task automatic test_vs_de_same();
    add(1'b1, 1'b1, mk(4'h0, 0, 1, 0, 0, 0, 0), M_NOPOS);
    addLine(8, 1, 0, 0, 0, 0, 1, 0, 0, 2);
    for (int c = 0; stimQ.size() > 0; c++) begin
      stim_t s; exp_t e; logic [18:0] o;
      s = stimQ.pop_front();
      bus.iVS = s.vs; bus.iDE = s.de; bus.iPixelData = s.pix;
      @(posedge clk); @(negedge clk);
      e = expQ.pop_front(); o = obsVec(); testsRun++;
      if (((o & e.mask) !== (e.val & e.mask)) || (bus.oPixelData !== e.pix)) begin
        failCnt++;
        $display("FAIL vs_de_same cyc%0d: got %h pix %h want %h mask %h pix %h",
                 c, o, bus.oPixelData, e.val, e.mask, e.pix);
      end
    end
  endtask

  task automatic test_reset_mid_line();
    addVs();
    addLine(4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; stimQ.size() > 0; c++) begin
      stim_t s; exp_t e; logic [18:0] o;
      s = stimQ.pop_front();
      bus.iVS = s.vs; bus.iDE = s.de; bus.iPixelData = s.pix;
      @(posedge clk); @(negedge clk);
      e = expQ.pop_front(); o = obsVec(); testsRun++;
      if (((o & e.mask) !== (e.val & e.mask)) || (bus.oPixelData !== e.pix)) begin
        failCnt++;
        $display("FAIL reset_mid_pre cyc%0d: got %h pix %h want %h mask %h pix %h",
                 c, o, bus.oPixelData, e.val, e.mask, e.pix);
      end
    end
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if (obsVec() !== 19'h0) begin
      failCnt++;
      $display("FAIL async_reset_ctrl: got %h want 0", obsVec());
    end
    testsRun++;
    if (bus.oPixelData !== 192'h0) begin
      failCnt++;
      $display("FAIL async_reset_pix: got %h want 0", bus.oPixelData);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) add(1'b0, 1'b1, mk(4'h0, 0, 0, 0, 0, 0, 0), M_ALL);
    add(1'b0, 1'b0, mk(4'h0, 0, 0, 0, 0, 0, 0), M_ALL);
    add(1'b0, 1'b0, mk(4'h0, 0, 0, 0, 0, 0, 0), M_ALL);
    for (int c = 0; stimQ.size() > 0; c++) begin
      stim_t s; exp_t e; logic [18:0] o;
      s = stimQ.pop_front();
      bus.iVS = s.vs; bus.iDE = s.de; bus.iPixelData = s.pix;
      @(posedge clk); @(negedge clk);
      e = expQ.pop_front(); o = obsVec(); testsRun++;
      if (((o & e.mask) !== (e.val & e.mask)) || (bus.oPixelData !== e.pix)) begin
        failCnt++;
        $display("FAIL reset_no_vs cyc%0d: got %h pix %h want %h mask %h pix %h",
                 c, o, bus.oPixelData, e.val, e.mask, e.pix);
      end
    end
  endtask

  initial begin
    testsRun = 0;
    failCnt  = 0;
    test_reset();
    test_first_line();
    test_block_pulses();
    test_mid_line_vs();
    test_long_line();
    test_vs_de_same();
    test_reset_mid_line();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
    $finish;
  end
endmodule
